// File: rtl/cellrv32_dmem_mp_pkg.sv
// Shared types and parameter limits for the multi-port data memory.
// Holds the per-port request record, the pipeline tag and a one-hot to index helper.
package cellrv32_package;

    localparam int NUM_PORTS_MIN  = 1;
    localparam int NUM_PORTS_MAX  = 4;
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 3;
    localparam int PORT_ID_W      = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        logic        rd;
        logic        wr;
    } port_req_t;

    typedef struct packed {
        logic                 vld;
        logic                 rd;
        logic [PORT_ID_W-1:0] port;
    } pipe_tag_t;

    function automatic logic [PORT_ID_W-1:0] onehot_to_idx(input logic [NUM_PORTS_MAX-1:0] oh);
        logic [PORT_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS_MAX; i++) begin
            if (oh[i]) idx = idx | PORT_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cellrv32_dmem_mp_if.sv
// Bundled per-port bus of the multi-port data memory.
// Signal names follow the memory's point of view (_i into the memory, _o out of it).
interface cellrv32_dmem_mp_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]       rden_i;
    logic [NUM_PORTS-1:0]       wren_i;
    logic [NUM_PORTS-1:0][3:0]  ben_i;
    logic [NUM_PORTS-1:0][31:0] addr_i;
    logic [NUM_PORTS-1:0][31:0] data_i;
    logic [NUM_PORTS-1:0][31:0] data_o;
    logic [NUM_PORTS-1:0]       ack_o;
    logic [NUM_PORTS-1:0]       err_o;

    modport master (
        output rden_i, wren_i, ben_i, addr_i, data_i,
        input  data_o, ack_o, err_o
    );

    modport slave (
        input  rden_i, wren_i, ben_i, addr_i, data_i,
        output data_o, ack_o, err_o
    );
endinterface

// File: rtl/cellrv32_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the port after the last grant.
// The pointer holds when nothing requests.
module cellrv32_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] pick;
    logic               found;

    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        req_hi  = '0;
        gnt     = '0;
        ptr_nxt = ptr_q;
        found   = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_hi[j] = req[j] && (j >= int'(ptr_q));
        end
        pick = (req_hi != '0) ? req_hi : req;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && pick[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                ptr_nxt = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; blocking ones stay in combinational logic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/cellrv32_dmem_mp.sv
// Multi-port data memory: per-port pending slot, round-robin arbitration with bypass,
// byte-lane RAM and a fixed-latency ack pipeline shared by reads and writes.
module cellrv32_dmem_mp
    import cellrv32_package::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h00000000,
    parameter int          DMEM_SIZE  = 8192,
    parameter int          NUM_PORTS  = 2,
    parameter int          RD_LATENCY = 1
) (
    input logic               clk_i,
    input logic               rst_i,
    cellrv32_dmem_mp_if.slave bus
);

    localparam int ADDR_LO = $clog2(DMEM_SIZE);
    localparam int WA_W    = ADDR_LO - 2;
    localparam int WORDS   = DMEM_SIZE / 4;

    if (NUM_PORTS < NUM_PORTS_MIN || NUM_PORTS > NUM_PORTS_MAX) begin : g_bad_ports
        $error("cellrv32_dmem_mp: NUM_PORTS out of range");
    end
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("cellrv32_dmem_mp: RD_LATENCY out of range");
    end
    if (DMEM_SIZE < 16 || (DMEM_SIZE & (DMEM_SIZE - 1)) != 0) begin : g_bad_size
        $error("cellrv32_dmem_mp: DMEM_SIZE must be a power of two >= 16");
    end
    if ((DMEM_BASE & 32'(DMEM_SIZE - 1)) != 32'h0) begin : g_bad_base
        $error("cellrv32_dmem_mp: DMEM_BASE not aligned to DMEM_SIZE");
    end

    port_req_t [NUM_PORTS-1:0] slot_q;
    port_req_t [NUM_PORTS-1:0] cur_req;
    logic      [NUM_PORTS-1:0] slot_vld_q;
    logic      [NUM_PORTS-1:0] strobe;
    logic      [NUM_PORTS-1:0] err_now;
    logic      [NUM_PORTS-1:0] accept;
    logic      [NUM_PORTS-1:0] req;
    logic      [NUM_PORTS-1:0] gnt;
    logic      [NUM_PORTS-1:0] err_q;

    // A pending slot takes precedence as the port's request; otherwise a clean new strobe bypasses.
    always_comb begin
        strobe  = '0;
        err_now = '0;
        accept  = '0;
        req     = '0;
        cur_req = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            strobe[p]  = (bus.addr_i[p][31:ADDR_LO] == DMEM_BASE[31:ADDR_LO]) &&
                         (bus.rden_i[p] || bus.wren_i[p]);
            err_now[p] = strobe[p] && ((bus.rden_i[p] && bus.wren_i[p]) || slot_vld_q[p]);
            accept[p]  = strobe[p] && !err_now[p];
            req[p]     = slot_vld_q[p] || accept[p];
            cur_req[p] = slot_vld_q[p] ? slot_q[p] :
                         '{addr: bus.addr_i[p], data: bus.data_i[p], ben: bus.ben_i[p],
                           rd: bus.rden_i[p], wr: bus.wren_i[p]};
        end
    end

    cellrv32_rr_arbiter #(
        .NUM_REQ (NUM_PORTS)
    ) u_arbiter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (req),
        .gnt   (gnt)
    );

    // A strobe granted in its own cycle never occupies the slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_vld_q <= '0;
            slot_q     <= '0;
            err_q      <= '0;
        end else begin
            err_q <= err_now;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p]) begin
                    slot_vld_q[p] <= 1'b0;
                end else if (accept[p]) begin
                    slot_vld_q[p] <= 1'b1;
                    slot_q[p]     <= cur_req[p];
                end
            end
        end
    end

    port_req_t                  g_req;
    logic                       g_valid;
    logic [PORT_ID_W-1:0]       g_port;
    logic [NUM_PORTS_MAX-1:0]   gnt_pad;

    always_comb begin
        g_req   = '0;
        gnt_pad = '0;
        gnt_pad[NUM_PORTS-1:0] = gnt;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) g_req = cur_req[p];
        end
    end

    assign g_valid = |gnt;
    assign g_port  = onehot_to_idx(gnt_pad);

    logic [WA_W-1:0]  waddr;
    logic [3:0]       lane_we;
    logic [3:0][7:0]  mem_rdata;
    logic             unused_addr_bits;

    assign waddr            = g_req.addr[ADDR_LO-1:2];
    assign lane_we          = {4{g_valid && g_req.wr}} & g_req.ben;
    assign unused_addr_bits = ^{g_req.addr[31:ADDR_LO], g_req.addr[1:0]};

    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] ram [WORDS];
        logic [7:0] rdata;

        // NOTE: the RAM has no reset branch, so its contents survive rst_i and it maps onto block RAM.
        always_ff @(posedge clk_i) begin
            if (lane_we[b]) begin
                ram[waddr] <= g_req.data[8*b +: 8];
            end else begin
                rdata <= ram[waddr];
            end
        end

        assign mem_rdata[b] = rdata;
    end

    pipe_tag_t [RD_LATENCY-1:0] tag_q;
    pipe_tag_t                  last_tag;
    logic      [31:0]           out_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= '{vld: g_valid, rd: g_req.rd, port: g_port};
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Stage 0 data is the RAM output register itself; later stages only delay it.
    if (RD_LATENCY > 1) begin : g_pipe
        logic [RD_LATENCY-2:0][31:0] data_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                data_q <= '0;
            end else begin
                data_q[0] <= mem_rdata;
                for (int k = 1; k < RD_LATENCY - 1; k++) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end

        assign out_data = data_q[RD_LATENCY-2];
    end else begin : g_nopipe
        assign out_data = mem_rdata;
    end

    assign last_tag = tag_q[RD_LATENCY-1];

    always_comb begin
        bus.ack_o  = '0;
        bus.data_o = '0;
        bus.err_o  = err_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (last_tag.vld && last_tag.port == PORT_ID_W'(p)) begin
                bus.ack_o[p] = 1'b1;
                if (last_tag.rd) bus.data_o[p] = out_data;
            end
        end
    end

endmodule

// File: tb/tb_cellrv32_dmem_mp.sv
// Directed bench: a two-port latency-1 memory driven from a cycle table, plus a
// one-port latency-3 memory at a non-zero base and an in-flight reset sequence.
module tb_cellrv32_dmem_mp;

    localparam logic [31:0] Z = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cellrv32_dmem_mp_if #(.NUM_PORTS(2)) bus0 ();
    cellrv32_dmem_mp_if #(.NUM_PORTS(1)) bus1 ();

    cellrv32_dmem_mp #(
        .DMEM_BASE  (32'h00000000),
        .DMEM_SIZE  (8192),
        .NUM_PORTS  (2),
        .RD_LATENCY (1)
    ) u_dut_p2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    cellrv32_dmem_mp #(
        .DMEM_BASE  (32'h00000100),
        .DMEM_SIZE  (64),
        .NUM_PORTS  (1),
        .RD_LATENCY (3)
    ) u_dut_l3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    // One row = inputs applied in a cycle plus the outputs expected in that same cycle
    // (which result from earlier rows). Port 1 sits in the upper half of each field.
    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [7:0]  ben;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic [7:0] ben,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] ack, input logic [1:0] err, input logic [63:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ben = ben; v.addr = addr; v.wdata = wdata;
        v.ack = ack; v.err = err; v.rdata = rdata;
        vecs.push_back(v);
    endtask

    task automatic drive0(input logic [1:0] rd, input logic [1:0] wr, input logic [7:0] ben,
                          input logic [63:0] addr, input logic [63:0] wdata);
        bus0.rden_i = rd;
        bus0.wren_i = wr;
        bus0.ben_i  = ben;
        bus0.addr_i = addr;
        bus0.data_i = wdata;
    endtask

    task automatic drive1(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bus1.rden_i = rd;
        bus1.wren_i = wr;
        bus1.ben_i  = 4'hF;
        bus1.addr_i = addr;
        bus1.data_i = wdata;
    endtask

    task automatic check0(input string name, input logic [1:0] ack, input logic [1:0] err,
                          input logic [63:0] rdata);
        check({name, " ack"},  64'(bus0.ack_o),  64'(ack));
        check({name, " err"},  64'(bus0.err_o),  64'(err));
        check({name, " data"}, 64'(bus0.data_o), rdata);
    endtask

    task automatic build_table();
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b01, 8'h0F, {Z, 32'h10},       {Z, 32'hDEADBEEF},            2'b00, 2'b00, {Z, Z});
        add(2'b01, 2'b00, 8'h00, {Z, 32'h10},       {Z, Z},                       2'b01, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b01, 2'b00, {Z, 32'hDEADBEEF});
        add(2'b00, 2'b01, 8'h0F, {Z, 32'h20},       {Z, 32'h11223344},            2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b01, 8'h01, {Z, 32'h20},       {Z, 32'h000000AA},            2'b01, 2'b00, {Z, Z});
        add(2'b01, 2'b00, 8'h00, {Z, 32'h20},       {Z, Z},                       2'b01, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b01, 2'b00, {Z, 32'h112233AA});
        add(2'b00, 2'b10, 8'hF0, {32'h30, Z},       {32'h55667788, Z},            2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b10, 2'b00, {Z, Z});
        // Simultaneous reads with the pointer at port 0.
        add(2'b11, 2'b00, 8'h00, {32'h30, 32'h10},  {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b01, 2'b00, {Z, 32'hDEADBEEF});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b10, 2'b00, {32'h55667788, Z});
        // Read and write together: error only, memory untouched.
        add(2'b01, 2'b01, 8'h0F, {Z, 32'h10},       {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b00, 2'b01, {Z, Z});
        add(2'b01, 2'b00, 8'h00, {Z, 32'h10},       {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b01, 2'b00, {Z, 32'hDEADBEEF});
        // Pointer at port 1: port 1 wins, port 0 parks; a strobe in port 0's grant cycle is dropped.
        add(2'b11, 2'b00, 8'h00, {32'h10, 32'h20},  {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b01, 8'h0F, {Z, 32'h20},       {Z, 32'hFFFFFFFF},            2'b10, 2'b00, {32'hDEADBEEF, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b01, 2'b01, {Z, 32'h112233AA});
        add(2'b01, 2'b00, 8'h00, {Z, 32'h20},       {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b01, 2'b00, {Z, 32'h112233AA});
        // Out-of-window addresses that would alias onto 0x10.
        add(2'b01, 2'b10, 8'hF0, {32'h2010, 32'h2010}, {32'h12345678, Z},         2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b10, 8'hC0, {32'h30, Z},       {32'hCAFE0000, Z},            2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b10, 2'b00, {Z, Z});
        add(2'b10, 2'b00, 8'h00, {32'h30, Z},       {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b10, 2'b00, {32'hCAFE7788, Z});
        add(2'b01, 2'b00, 8'h00, {Z, 32'h10},       {Z, Z},                       2'b00, 2'b00, {Z, Z});
        add(2'b00, 2'b00, 8'h00, {Z, Z},            {Z, Z},                       2'b01, 2'b00, {Z, 32'hDEADBEEF});
    endtask

    logic [31:0] words [3];
    logic        exp_ack1;
    logic [31:0] exp_data1;

    initial begin
        drive0(2'b00, 2'b00, 8'h00, {Z, Z}, {Z, Z});
        drive1(1'b0, 1'b0, Z, Z);
        build_table();
        words[0] = 32'hA5A50001;
        words[1] = 32'h5A5A0002;
        words[2] = 32'h0F0F0003;

        repeat (3) @(negedge clk);
        check0("reset", 2'b00, 2'b00, {Z, Z});
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            check0($sformatf("row%0d", i), vecs[i].ack, vecs[i].err, vecs[i].rdata);
            drive0(vecs[i].rd, vecs[i].wr, vecs[i].ben, vecs[i].addr, vecs[i].wdata);
        end

        // Reset with port 0 in the ack stage and port 1 parked in its slot, pointer at 1.
        @(negedge clk);
        drive0(2'b10, 2'b00, 8'h00, {32'h30, Z}, {Z, Z});
        @(negedge clk);
        drive0(2'b11, 2'b00, 8'h00, {32'h30, 32'h10}, {Z, Z});
        @(negedge clk);
        check0("pre_rst", 2'b01, 2'b00, {Z, 32'hDEADBEEF});
        drive0(2'b00, 2'b00, 8'h00, {Z, Z}, {Z, Z});
        rst = 1'b1;
        #1;
        check0("async_rst", 2'b00, 2'b00, {Z, Z});
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check0($sformatf("post_rst%0d", i), 2'b00, 2'b00, {Z, Z});
        end
        drive0(2'b11, 2'b00, 8'h00, {32'h30, 32'h10}, {Z, Z});
        @(negedge clk);
        check0("rr_after_rst_p0", 2'b01, 2'b00, {Z, 32'hDEADBEEF});
        drive0(2'b00, 2'b00, 8'h00, {Z, Z}, {Z, Z});
        @(negedge clk);
        check0("rr_after_rst_p1", 2'b10, 2'b00, {32'hCAFE7788, Z});

        // Latency-3 port: three writes, three back-to-back reads, then an out-of-window
        // write at 0x140 and a read of 0x100 that would expose aliasing.
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            exp_ack1  = (t >= 3 && t <= 8) || t == 10;
            exp_data1 = (t >= 6 && t <= 8) ? words[t-6] : (t == 10) ? words[0] : Z;
            check($sformatf("l3 t%0d ack", t),  64'(bus1.ack_o),  64'(exp_ack1));
            check($sformatf("l3 t%0d err", t),  64'(bus1.err_o),  64'(0));
            check($sformatf("l3 t%0d data", t), 64'(bus1.data_o), 64'(exp_data1));
            if (t < 3)       drive1(1'b0, 1'b1, 32'h100 + 32'(4 * t), words[t]);
            else if (t < 6)  drive1(1'b1, 1'b0, 32'h100 + 32'(4 * (t - 3)), Z);
            else if (t == 6) drive1(1'b0, 1'b1, 32'h140, 32'h00000BAD);
            else if (t == 7) drive1(1'b1, 1'b0, 32'h100, Z);
            else             drive1(1'b0, 1'b0, Z, Z);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
